// File: rtl/sram_device_model.sv
`default_nettype none
// ============================================================================
// Module   : sram_device_model
// Purpose  : Clocked stand-in for a 16-bit async SRAM with enforced access
//            latencies, access counters and a sticky protocol-error flag.
//            Optional upper-address range checking: SRAM_MODEL_ADDR_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sram_device_model #(
  parameter int DEPTH_LOG2 = 12,
  parameter int READ_LAT   = 2,
  parameter int WRITE_LAT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [15:0] SRAM_DQ,
  input  logic [17:0] SRAM_ADDR,
  input  logic        SRAM_UB_N,
  input  logic        SRAM_LB_N,
  input  logic        SRAM_WE_N,
  input  logic        SRAM_CE_N,
  input  logic        SRAM_OE_N,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic        protocol_error
);

  localparam int       c_depth  = 1 << DEPTH_LOG2;
  localparam bit [3:0] c_rd_lat = 4'(READ_LAT);
  localparam bit [3:0] c_wr_lat = 4'(WRITE_LAT);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    READ_DRIVE = 2'd2,
    WRITE_WAIT = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [3:0]            r_cnt;
  logic [3:0]            w_next_cnt;
  logic [17:0]           r_addr;
  logic [17:0]           w_next_addr;
  logic                  w_rd_done;
  logic                  w_wr_commit;
  logic                  w_err_set;
  logic                  w_write_req;
  logic                  w_read_req;
  logic                  w_addr_chg;
  logic                  w_oor;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [15:0]           w_rd_data;
  logic [15:0]           r_mem [c_depth];

  assign w_write_req = !SRAM_CE_N && !SRAM_WE_N;
  assign w_read_req  = !SRAM_CE_N && SRAM_WE_N && !SRAM_OE_N;
  assign w_addr_chg  = (SRAM_ADDR != r_addr);
  assign w_idx       = r_addr[DEPTH_LOG2-1:0];

`ifdef SRAM_MODEL_ADDR_CHECK_EN
  localparam bit [17:0] c_hi_mask = ~((18'd1 << DEPTH_LOG2) - 18'd1);
  assign w_oor = |(r_addr & c_hi_mask);
`else
  assign w_oor = 1'b0;
`endif

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_addr  = r_addr;
    w_rd_done    = 1'b0;
    w_wr_commit  = 1'b0;
    w_err_set    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_write_req) begin
          w_next_state = WRITE_WAIT;
          w_next_addr  = SRAM_ADDR;
          w_next_cnt   = 4'd1;
        end else if (w_read_req) begin
          w_next_state = READ_WAIT;
          w_next_addr  = SRAM_ADDR;
          w_next_cnt   = 4'd1;
        end
      end
      READ_WAIT: begin
        if (w_write_req) begin
          w_err_set    = 1'b1;
          w_next_state = WRITE_WAIT;
          w_next_addr  = SRAM_ADDR;
          w_next_cnt   = 4'd1;
        end else if (!w_read_req) begin
          w_next_state = IDLE;
          w_next_cnt   = 4'd0;
        end else if (w_addr_chg) begin
          w_next_addr  = SRAM_ADDR;
          w_next_cnt   = 4'd1;
        end else if (r_cnt == c_rd_lat) begin
          w_next_state = READ_DRIVE;
          w_rd_done    = 1'b1;
        end else begin
          w_next_cnt   = r_cnt + 4'd1;
        end
      end
      READ_DRIVE: begin
        if (w_write_req) begin
          // Controller turned the bus around while we are still driving it.
          w_err_set    = 1'b1;
          w_next_state = WRITE_WAIT;
          w_next_addr  = SRAM_ADDR;
          w_next_cnt   = 4'd1;
        end else if (!w_read_req) begin
          w_next_state = IDLE;
          w_next_cnt   = 4'd0;
        end else if (w_addr_chg) begin
          w_next_state = READ_WAIT;
          w_next_addr  = SRAM_ADDR;
          w_next_cnt   = 4'd1;
        end
      end
      WRITE_WAIT: begin
        if (r_cnt == c_wr_lat) begin
          w_wr_commit  = 1'b1;
          w_next_state = IDLE;
          w_next_cnt   = 4'd0;
        end else if (!w_write_req) begin
          w_err_set    = 1'b1;
          w_next_state = IDLE;
          w_next_cnt   = 4'd0;
        end else if (w_addr_chg) begin
          w_err_set    = 1'b1;
          w_next_addr  = SRAM_ADDR;
          w_next_cnt   = 4'd1;
        end else begin
          w_next_cnt   = r_cnt + 4'd1;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_cnt   = 4'd0;
      end
    endcase
    if (r_state != IDLE && w_oor) begin
      w_err_set = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_cnt          <= 4'd0;
      r_addr         <= 18'd0;
      rd_count       <= 16'd0;
      wr_count       <= 16'd0;
      protocol_error <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_addr  <= w_next_addr;
      if (w_rd_done) begin
        rd_count <= rd_count + 16'd1;
      end
      if (w_wr_commit) begin
        wr_count <= wr_count + 16'd1;
      end
      if (w_err_set) begin
        protocol_error <= 1'b1;
      end
    end
  end

  // Array is never reset; commits are already blocked because reset forces IDLE.
  always_ff @(posedge clk) begin
    if (w_wr_commit && !w_oor) begin
      if (!SRAM_UB_N) begin
        r_mem[w_idx][15:8] <= SRAM_DQ[15:8];
      end
      if (!SRAM_LB_N) begin
        r_mem[w_idx][7:0] <= SRAM_DQ[7:0];
      end
    end
  end

  assign w_rd_data = w_oor ? 16'hDEAD : r_mem[w_idx];

  assign SRAM_DQ[15:8] = (r_state == READ_DRIVE && !SRAM_UB_N) ? w_rd_data[15:8] : 8'hzz;
  assign SRAM_DQ[7:0]  = (r_state == READ_DRIVE && !SRAM_LB_N) ? w_rd_data[7:0]  : 8'hzz;

endmodule
`default_nettype wire
